// File: rtl/decode_execute_core.sv
// decode_execute_core: IF/ID register, instruction decode and execute stage of the RV64 pipeline
// Ports:
//   clk, rst (async, active-low)
//   instr_in, ifid_write, ifid_flush      fetch side, IF/ID load/hold/clear
//   wb_we, wb_addr, wb_data               register file write port
//   instr_d, rs1_data, rs2_data, immediate decoded instruction fields
//   branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op  main control
//   alu_ctrl, alu_result, alu_zero        execute results
module decode_execute_core #(
   parameter int XLEN     = 64,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr_in,
   input  logic            ifid_write,
   input  logic            ifid_flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic [31:0]     instr_d,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] immediate,
   output logic            branch,
   output logic            mem_read,
   output logic            mem_to_reg,
   output logic            mem_write,
   output logic            alu_src,
   output logic            reg_write,
   output logic [1:0]      alu_op,
   output logic [3:0]      alu_ctrl,
   output logic [XLEN-1:0] alu_result,
   output logic            alu_zero
);
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   logic [XLEN-1:0] regs [NUM_REGS];
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [3:0]      f3_ctrl;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [7:0]      ctrl;
   logic [XLEN-1:0] op_b;
   always_ff @(posedge clk or negedge rst)
      if (!rst) instr_d <= '0;
      else if (ifid_flush) instr_d <= '0;
      else if (ifid_write) instr_d <= instr_in;
   always_ff @(posedge clk or negedge rst)
      if (!rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (wb_we && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
   assign opcode   = instr_d[6:0];
   assign funct3   = instr_d[14:12];
   assign rs1_addr = instr_d[19:15];
   assign rs2_addr = instr_d[24:20];
   // Write-through lets an instruction see a value being written back this same cycle.
   assign rs1_data = (rs1_addr == 5'd0) ? '0 : (wb_we && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 : (wb_we && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];
   assign immediate = (opcode == OP_LD || opcode == OP_IMM) ? {{(XLEN-12){instr_d[31]}}, instr_d[31:20]} :
                      (opcode == OP_SD)  ? {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]} :
                      (opcode == OP_BEQ) ? {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0} :
                      '0;
   // {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
   assign ctrl = (opcode == OP_R)   ? 8'b0010_0010 :
                 (opcode == OP_LD)  ? 8'b1111_0000 :
                 (opcode == OP_SD)  ? 8'b1000_1000 :
                 (opcode == OP_BEQ) ? 8'b0000_0101 :
                 (opcode == OP_IMM) ? 8'b1010_0011 :
                 8'b0000_0000;
   assign {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} = ctrl;
   // funct7 bit 5 selects SUB only for register-register ops; OP-IMM has no subtract.
   assign f3_ctrl = (funct3 == 3'b111) ? ALU_AND :
                    (funct3 == 3'b110) ? ALU_OR  :
                    (funct3 == 3'b100) ? ALU_XOR :
                    (funct3 == 3'b000 && alu_op == 2'b10 && instr_d[30]) ? ALU_SUB :
                    ALU_ADD;
   assign alu_ctrl = (alu_op == 2'b00) ? ALU_ADD : (alu_op == 2'b01) ? ALU_SUB : f3_ctrl;
   assign op_b = alu_src ? immediate : rs2_data;
   assign alu_result = (alu_ctrl == ALU_ADD) ? rs1_data + op_b :
                       (alu_ctrl == ALU_SUB) ? rs1_data - op_b :
                       (alu_ctrl == ALU_AND) ? rs1_data & op_b :
                       (alu_ctrl == ALU_OR)  ? rs1_data | op_b :
                       (alu_ctrl == ALU_XOR) ? rs1_data ^ op_b :
                       '0;
   assign alu_zero = (alu_result == '0);
endmodule

// File: tb/tb_decode_execute_core.sv
// tb_decode_execute_core: directed and randomized checks of decode_execute_core against a behavioural model
module tb_decode_execute_core;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_in;
   logic        ifid_write;
   logic        ifid_flush;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;
   logic [31:0] instr_d;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic [63:0] immediate;
   logic        branch;
   logic        mem_read;
   logic        mem_to_reg;
   logic        mem_write;
   logic        alu_src;
   logic        reg_write;
   logic [1:0]  alu_op;
   logic [3:0]  alu_ctrl;
   logic [63:0] alu_result;
   logic        alu_zero;
   int total = 0;
   int bad = 0;
   logic [63:0] mregs [32];
   logic [31:0] m_instr;
   decode_execute_core dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .instr_d(instr_d),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .immediate(immediate),
      .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
      .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return mregs[a];
   endfunction
   task automatic model_reset();
      m_instr = 32'd0;
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
   endtask
   // Expected outputs derived from the instruction semantics of the model's IF/ID copy.
   task automatic check_all(input string tag);
      logic [6:0] op;
      logic [2:0] f3;
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      logic [63:0] imm, a, b, res;
      logic e_src, e_mtr, e_rw, e_mr, e_mw, e_br;
      logic [1:0] e_op;
      logic [3:0] e_ctrl;
      op = m_instr[6:0];
      f3 = m_instr[14:12];
      imm = 64'd0;
      {e_src, e_mtr, e_rw, e_mr, e_mw, e_br, e_op} = '0;
      case (op)
         7'h33: begin e_rw = 1; e_op = 2; end
         7'h03: begin e_src = 1; e_mtr = 1; e_rw = 1; e_mr = 1; i12 = m_instr[31:20]; imm = i12; end
         7'h23: begin e_src = 1; e_mw = 1; i12 = {m_instr[31:25], m_instr[11:7]}; imm = i12; end
         7'h63: begin e_br = 1; e_op = 1; b13 = {m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8], 1'b0}; imm = b13; end
         7'h13: begin e_src = 1; e_rw = 1; e_op = 3; i12 = m_instr[31:20]; imm = i12; end
         default: ;
      endcase
      a = mread(m_instr[19:15]);
      b = e_src ? imm : mread(m_instr[24:20]);
      if (op == 7'h33 || op == 7'h13) begin
         case (f3)
            3'd7: begin e_ctrl = 4'b0000; res = a & b; end
            3'd6: begin e_ctrl = 4'b0001; res = a | b; end
            3'd4: begin e_ctrl = 4'b0011; res = a ^ b; end
            default: begin
               if (f3 == 3'd0 && op == 7'h33 && m_instr[30]) begin e_ctrl = 4'b0110; res = a - b; end
               else begin e_ctrl = 4'b0010; res = a + b; end
            end
         endcase
      end else if (op == 7'h63) begin
         e_ctrl = 4'b0110; res = a - b;
      end else begin
         e_ctrl = 4'b0010; res = a + b;
      end
      chk($sformatf("%s.instr_d", tag), 64'(instr_d), 64'(m_instr));
      chk($sformatf("%s.rs1", tag), rs1_data, mread(m_instr[19:15]));
      chk($sformatf("%s.rs2", tag), rs2_data, mread(m_instr[24:20]));
      chk($sformatf("%s.imm", tag), immediate, imm);
      chk($sformatf("%s.ctrl", tag), 64'({alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}),
          64'({e_src, e_mtr, e_rw, e_mr, e_mw, e_br, e_op}));
      chk($sformatf("%s.alu_ctrl", tag), 64'(alu_ctrl), 64'(e_ctrl));
      chk($sformatf("%s.result", tag), alu_result, res);
      chk($sformatf("%s.zero", tag), 64'(alu_zero), 64'(res == 64'd0));
   endtask
   // Drive one cycle of inputs, optionally check combinational outputs before the edge, then clock.
   task automatic step(input logic [31:0] ins, input logic wr, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [63:0] wd, input logic pre_check);
      instr_in = ins; ifid_write = wr; ifid_flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
      #1;
      if (pre_check) check_all("pre");
      @(posedge clk);
      m_instr = fl ? 32'd0 : wr ? ins : m_instr;
      if (we && wa != 5'd0) mregs[wa] = wd;
      #1;
      wb_we = 0; ifid_write = 0; ifid_flush = 0;
      #1;
   endtask
   task automatic load(input logic [31:0] ins);
      step(ins, 1, 0, 0, 5'd0, 64'd0, 0);
   endtask
   task automatic wr_reg(input logic [4:0] a, input logic [63:0] d);
      step(32'd0, 0, 0, 1, a, d, 0);
   endtask
   initial begin
      logic [6:0] ops [6];
      logic [31:0] ins;
      ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h37};
      rst = 0; instr_in = 32'hFFFF_FFFF; ifid_write = 1; ifid_flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
      model_reset();
      #12;
      chk("rst.instr_d", 64'(instr_d), 64'd0);
      chk("rst.zero", 64'(alu_zero), 64'd1);
      chk("rst.result", alu_result, 64'd0);
      rst = 1; ifid_write = 0;
      @(posedge clk); #2;
      check_all("reset");
      for (int i = 0; i < 32; i++) begin
         ins = {7'd0, 5'(31 - i), 5'(i), 3'd0, 5'd0, 7'h33};
         load(ins);
         chk($sformatf("rd0.x%0d", i), rs1_data, 64'd0);
         check_all("rd0");
      end
      wr_reg(5'd1, 64'd15);
      wr_reg(5'd2, 64'd5);
      load(32'h0020_81B3);
      chk("add.result", alu_result, 64'd20);
      chk("add.alu_ctrl", 64'(alu_ctrl), 64'h2);
      chk("add.alu_op", 64'(alu_op), 64'h2);
      check_all("add");
      load(32'h4020_81B3);
      chk("sub.result", alu_result, 64'd10);
      chk("sub.alu_ctrl", 64'(alu_ctrl), 64'h6);
      load(32'hFEC0_8293);
      chk("addi.imm", immediate, 64'hFFFF_FFFF_FFFF_FFEC);
      chk("addi.result", alu_result, 64'hFFFF_FFFF_FFFF_FFFB);
      chk("addi.alu_src", 64'(alu_src), 64'd1);
      check_all("addi");
      load(32'h0080_B203);
      chk("ld.result", alu_result, 64'd23);
      chk("ld.mem_read", 64'({mem_read, mem_to_reg}), 64'h3);
      check_all("ld");
      load(32'h0020_B823);
      chk("sd.imm", immediate, 64'd16);
      chk("sd.result", alu_result, 64'd31);
      chk("sd.mw_rw", 64'({mem_write, reg_write}), 64'h2);
      check_all("sd");
      load(32'hFE10_8CE3);
      chk("beq_eq.imm", immediate, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("beq_eq.zero", 64'(alu_zero), 64'd1);
      chk("beq_eq.branch", 64'(branch), 64'd1);
      chk("beq_eq.alu_ctrl", 64'(alu_ctrl), 64'h6);
      load(32'hFE20_8CE3);
      chk("beq_ne.zero", 64'(alu_zero), 64'd0);
      check_all("beq_ne");
      wr_reg(5'd0, 64'd99);
      load(32'h0000_0033);
      chk("x0.rs1", rs1_data, 64'd0);
      load(32'h0003_03B3);
      wb_we = 1; wb_addr = 5'd6; wb_data = 64'hDEAD_BEEF_0123_4567;
      #1;
      chk("wthru.rs1", rs1_data, 64'hDEAD_BEEF_0123_4567);
      step(32'd0, 0, 0, 1, 5'd6, 64'hDEAD_BEEF_0123_4567, 1);
      check_all("wthru.after");
      step(32'h1234_5013, 0, 0, 0, 5'd0, 64'd0, 0);
      chk("hold.instr_d", 64'(instr_d), 64'h0003_03B3);
      step(32'h1234_5013, 1, 1, 0, 5'd0, 64'd0, 0);
      chk("flush.instr_d", 64'(instr_d), 64'd0);
      check_all("flush");
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) ins[24:20] = ins[19:15];
         step(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0, 1'($urandom), 5'($urandom),
              ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 20)), 1);
         check_all($sformatf("rnd%0d", n));
      end
      #3 rst = 0;
      #1;
      chk("midrst.instr_d", 64'(instr_d), 64'd0);
      chk("midrst.zero", 64'(alu_zero), 64'd1);
      #2 rst = 1;
      model_reset();
      for (int i = 1; i < 32; i++) begin
         load({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33});
         chk($sformatf("midrst.x%0d", i), rs1_data, 64'd0);
      end
      check_all("midrst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decode_execute_core.md
Name: decode_execute_core

Overview:
- Front half of the 5-stage RV64 pipeline: IF/ID pipeline register, instruction decode (32x64 register file, immediate generator, main control) and execute (ALU control, 64-bit ALU).
- Receives fetched instructions from the fetch stage.
- Presents control signals, operands, the ALU result and the zero flag to the memory, write-back and branch logic.
- Write-back data enters through a dedicated write port.

Parameters:
- XLEN, 64, datapath and register width
- NUM_REGS, 32, register file depth (x0 hardwired zero)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- instr_in  input  32  instruction from fetch
- ifid_write  input  1  IF/ID load enable (0 = stall/hold)
- ifid_flush  input  1  synchronous IF/ID clear
- wb_we  input  1  register file write enable
- wb_addr  input  5  register file write address
- wb_data  input  64  register file write data
- instr_d  output  32  instruction held in IF/ID
- rs1_data  output  64  register read, instr_d[19:15]
- rs2_data  output  64  register read, instr_d[24:20]
- immediate  output  64  sign-extended immediate
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  output  1 each  main control
- alu_op  output  2  ALU operation class
- alu_ctrl  output  4  ALU function select
- alu_result  output  64  ALU output
- alu_zero  output  1  alu_result == 0

Behaviour:
- Reset (rst=0, asynchronous): instr_d=0 and all 32 registers = 0.
  - Resulting outputs: all control bits 0, alu_op=00, immediate=0, alu_result=0, alu_zero=1.
- IF/ID register, updated at the clk rising edge:
  - ifid_flush=1: instr_d<=0. Flush takes priority over ifid_write.
  - else ifid_write=1: instr_d<=instr_in.
  - else: instr_d holds.
- Latency: instr_in sampled at an edge; all decode/execute outputs valid combinationally after that edge (one cycle).
- Register file:
  - Write at the rising edge when wb_we=1 and wb_addr!=0.
  - Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational with write-through: if wb_we=1, wb_addr!=0 and wb_addr equals the read address, the read returns wb_data.
- Immediate by opcode (instr_d[6:0]):
  - 0000011 (ld) and 0010011 (OP-IMM): I-type, sext(instr[31:20]).
  - 0100011 (sd): S-type, sext({instr[31:25], instr[11:7]}).
  - 1100011 (beq): B-type byte offset, sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Any other opcode: 0.
- Main control, listed as alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op:
  - 0110011 R-type: 0,0,1,0,0,0,10
  - 0000011 ld: 1,1,1,1,0,0,00
  - 0100011 sd: 1,0,0,0,1,0,00
  - 1100011 beq: 0,0,0,0,0,1,01
  - 0010011 OP-IMM: 1,0,1,0,0,0,11
  - Any other opcode: all 0, alu_op 00.
- ALU control codes: ADD=0010, SUB=0110, AND=0000, OR=0001, XOR=0011.
  - alu_op 00: ADD. alu_op 01: SUB.
  - alu_op 10 (uses funct3=instr_d[14:12] and funct7b5=instr_d[30]):
    - funct3 000: ADD when funct7b5=0, SUB when funct7b5=1.
    - funct3 111: AND. 110: OR. 100: XOR. Other funct3: ADD.
  - alu_op 11: same funct3 mapping as alu_op 10, funct7b5 ignored, so funct3 000 is always ADD.
- ALU datapath:
  - Operand A = rs1_data; operand B = alu_src ? immediate : rs2_data.
  - 64-bit two's complement add/sub, wrap-around modulo 2^64, no overflow flag.
  - alu_zero = (alu_result == 0).
  - Unknown alu_ctrl value: result 0.
- Reset deasserted mid-operation: pipeline resumes from instr_d=0 with an empty register file.

Test Plan:
- Reset, then release → instr_d=0, all controls 0, alu_zero=1; every register reads 0.
- Write x1=15 and x2=5 via the wb port. Load add x3,x1,x2 (0x002081B3) → reg_write=1, alu_op=10, alu_ctrl=0010, alu_result=20. Load sub x3,x1,x2 (0x402081B3) → alu_ctrl=0110, alu_result=10.
- With x1=15, load addi x5,x1,-20 (0xFEC08293) → immediate=0xFFFF_FFFF_FFFF_FFEC, alu_src=1, alu_result=0xFFFF_FFFF_FFFF_FFFB.
- With x1=15, load ld x4,8(x1) → mem_read=1, mem_to_reg=1, alu_result=23. Load sd x2,16(x1) → mem_write=1, reg_write=0, immediate=16, alu_result=31.
- beq x1,x1,-8 → branch=1, alu_ctrl=0110, alu_zero=1, immediate=-8. beq with x1≠x2 → alu_zero=0.
- Write attempt to x0 with value 99 → x0 still reads 0. Same-cycle write/read of x6 returns wb_data. ifid_write=0 holds instr_d; ifid_flush=1 together with ifid_write=1 → instr_d=0.
